command_sequencer: RTL and testbench
====================================

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 Parameter FT_W, default 2: flash-type field width.
REQ-002 Parameter CMD_W, default 5: command-code width.
REQ-003 Parameter DEPTH, default 4: input queue depth, power of two, at least 2.
REQ-004 Parameter AUTO_WREN, default 1: when 1, write/erase commands get an automatic WREN prefix.
REQ-005 clk  in  1  clock; reset  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i  in  1  command request; cmd_ready_o  out  1  queue not full.
REQ-007 cmd_i  in  CMD_W  command code (cmd_e); flash_type_i  in  FT_W  0 Micron, 1 Winbond, 2 Infineon.
REQ-008 op_valid_o  out  1  opcode descriptor valid; op_ready_i  in  1  downstream accepts.
REQ-009 opcode_o  out  8  SPI opcode; addr_bytes_o  out  3  0/3; dummy_o  out  5  dummy cycles.
REQ-010 lanes_o  out  2  data lanes (0 = 1, 1 = 2, 2 = 4); has_data_o  out  1; last_o  out  1  final opcode of the command.
REQ-011 err_o  out  1  single-cycle pulse for an unsupported command/flash pair.

Function
REQ-012 Input transfer occurs when cmd_valid_i and cmd_ready_o are both high; {cmd_i, flash_type_i} is pushed into a FIFO of DEPTH entries.
REQ-013 cmd_ready_o is low only when the FIFO is full; a push and a pop in the same cycle while full is not allowed, since ready is already low.
REQ-014 FSM states are IDLE, DECODE, PRE, MAIN, RST2.
- IDLE -> DECODE when the FIFO is non-empty.
- DECODE pops one entry and looks it up.
REQ-015 DECODE exits:
- unsupported pair: err_o pulses for 1 cycle, next state IDLE, no op emitted.
- write/erase class (PP, SE, BE, BE64K, CE, QPP, WRSR, WRCR) with AUTO_WREN = 1: go to PRE.
- RST: go to PRE, which emits 0x66 (RST_EN).
- all others: go to MAIN.
REQ-016 PRE drives the prefix descriptor (0x06 or 0x66, no address, no data, last_o = 0) and moves to MAIN on op_valid_o && op_ready_i.
REQ-017 MAIN drives the decoded descriptor with last_o = 1 and returns to IDLE on the handshake. RST2 is reserved and behaves as MAIN with opcode 0x99.
REQ-018 Output descriptor fields are registered and held stable while op_valid_o = 1 and op_ready_i = 0.
REQ-019 Opcode table:
- READ 03/3/0/x1, FAST_READ 0B/3/8/x1, DUAL_READ 3B/3/8/x2, DUAL_IO_READ BB/3/4/x2, QUAD_READ 6B/3/8/x4, QUAD_IO_READ EB/3/6/x4.
- PP 02/3/0/x1; JEDEC 9F/0/0/x1; RDSR 05; WRSR 01; WREN 06; WRDI 04; RST_EN 66; RST 99.
- SE: Winbond 20, others D8.
- BE: Winbond 52, others C7.
- BE64K: Winbond D8 only.
- CE: Winbond C7 only.
- QPP 32, REMS 90, RDCR 35, WRCR 01: Infineon only.
- Any other code is unsupported.
REQ-020 Throughput: one descriptor per cycle when op_ready_i is held high; for a single-op command, DECODE-to-op_valid_o latency is 1 cycle.
REQ-021 A new cmd_valid_i during PRE or MAIN is queued and does not disturb the op in flight.

Reset
REQ-022 While reset is low:
- op_valid_o = 0, opcode_o = 0, addr_bytes_o = 0, dummy_o = 0, lanes_o = 0, has_data_o = 0, last_o = 0, err_o = 0.
- FIFO is empty, so cmd_ready_o = 1.
- FSM is in IDLE.
REQ-023 Reset asserted mid-sequence (PRE or MAIN) discards the sequence and all queued entries; no partial op is emitted after release.

Structure
REQ-024 The shared package qspi_cmd_pkg holds cmd_e, flash_type_e, the opcode constants, and the op descriptor struct.
REQ-025 The FIFO is a sub-module named cmd_fifo, parametrised by width and DEPTH.

Verification
REQ-026 Micron READ, op_ready_i = 1 -> one op: 0x03, addr 3, dummy 0, last_o = 1.
REQ-027 Winbond SE, AUTO_WREN = 1 -> 0x06 (last_o = 0), then 0x20 (last_o = 1).
REQ-028 RST on any flash type -> 0x66, then 0x99.
REQ-029 Micron QPP -> err_o pulses once, no op_valid_o, the next queued command proceeds.
REQ-030 op_ready_i held low for 5 cycles during QUAD_IO_READ -> 0xEB, dummy 6, lanes 2, all fields stable throughout.
REQ-031 Push 4 commands with op_ready_i = 0 -> cmd_ready_o drops after the 4th; reset mid-PRE -> outputs 0, cmd_ready_o = 1.

Source files
------------

// File: rtl/qspi_cmd_pkg.sv
// Shared definitions for the QSPI command sequencer.
//   cmd_e        : host-side command codes (5 bits)
//   flash_type_e : target flash vendor
//   OP_*         : SPI opcode bytes
//   op_desc_t    : one opcode descriptor as presented downstream
//   lookup()     : command/flash pair -> descriptor plus class flags
package qspi_cmd_pkg;

  typedef enum logic [4:0] {
    C_READ, C_FAST_READ, C_DUAL_READ, C_DUAL_IO_READ, C_QUAD_READ, C_QUAD_IO_READ,
    C_PP, C_JEDEC, C_RDSR, C_WRSR, C_WREN, C_WRDI, C_RST_EN, C_RST,
    C_SE, C_BE, C_BE64K, C_CE, C_QPP, C_REMS, C_RDCR, C_WRCR
  } cmd_e;

  typedef enum logic [1:0] {FT_MICRON, FT_WINBOND, FT_INFINEON} flash_type_e;

  localparam logic [7:0] OP_READ = 8'h03, OP_FAST_READ = 8'h0B, OP_DUAL_READ = 8'h3B;
  localparam logic [7:0] OP_DUAL_IO = 8'hBB, OP_QUAD_READ = 8'h6B, OP_QUAD_IO = 8'hEB;
  localparam logic [7:0] OP_PP = 8'h02, OP_JEDEC = 8'h9F, OP_RDSR = 8'h05, OP_WRSR = 8'h01;
  localparam logic [7:0] OP_WREN = 8'h06, OP_WRDI = 8'h04, OP_RST_EN = 8'h66, OP_RST = 8'h99;
  localparam logic [7:0] OP_SE_4K = 8'h20, OP_BLK_64K = 8'hD8, OP_BLK_32K = 8'h52;
  localparam logic [7:0] OP_CHIP_ER = 8'hC7, OP_QPP = 8'h32, OP_REMS = 8'h90;
  localparam logic [7:0] OP_RDCR = 8'h35, OP_WRCR = 8'h01;

  localparam logic [1:0] LANE_X1 = 2'd0, LANE_X2 = 2'd1, LANE_X4 = 2'd2;

  typedef struct packed {
    logic [7:0] opcode;
    logic [2:0] addr_bytes;
    logic [4:0] dummy;
    logic [1:0] lanes;
    logic       has_data;
    logic       last;
  } op_desc_t;

  typedef struct packed {
    logic     ok;   // pair is supported
    logic     wr;   // write/erase class, eligible for a WREN prefix
    logic     rst;  // needs the RST_EN prefix
    op_desc_t desc; // final opcode of the command
  } dec_t;

  function automatic op_desc_t mk(input logic [7:0] op, input logic [2:0] ab,
                                  input logic [4:0] dm, input logic [1:0] ln,
                                  input logic hd);
    mk = '{opcode: op, addr_bytes: ab, dummy: dm, lanes: ln, has_data: hd, last: 1'b1};
  endfunction

  // Prefix ops carry only an opcode: no address, no data, not last.
  function automatic op_desc_t pfx(input logic [7:0] op);
    pfx = '0;
    pfx.opcode = op;
  endfunction

  function automatic dec_t lookup(input logic [4:0] c, input logic [1:0] f);
    dec_t d;
    logic wb, inf;
    d   = '0;
    wb  = (f == FT_WINBOND);
    inf = (f == FT_INFINEON);
    d.ok = (f != 2'd3);  // encoding 3 names no known vendor
    case (c)
      C_READ:         d.desc = mk(OP_READ,      3'd3, 5'd0, LANE_X1, 1'b1);
      C_FAST_READ:    d.desc = mk(OP_FAST_READ, 3'd3, 5'd8, LANE_X1, 1'b1);
      C_DUAL_READ:    d.desc = mk(OP_DUAL_READ, 3'd3, 5'd8, LANE_X2, 1'b1);
      C_DUAL_IO_READ: d.desc = mk(OP_DUAL_IO,   3'd3, 5'd4, LANE_X2, 1'b1);
      C_QUAD_READ:    d.desc = mk(OP_QUAD_READ, 3'd3, 5'd8, LANE_X4, 1'b1);
      C_QUAD_IO_READ: d.desc = mk(OP_QUAD_IO,   3'd3, 5'd6, LANE_X4, 1'b1);
      C_PP:    begin d.desc = mk(OP_PP,   3'd3, 5'd0, LANE_X1, 1'b1); d.wr = 1'b1; end
      C_JEDEC:       d.desc = mk(OP_JEDEC, 3'd0, 5'd0, LANE_X1, 1'b1);
      C_RDSR:        d.desc = mk(OP_RDSR,  3'd0, 5'd0, LANE_X1, 1'b1);
      C_WRSR:  begin d.desc = mk(OP_WRSR, 3'd0, 5'd0, LANE_X1, 1'b1); d.wr = 1'b1; end
      C_WREN:        d.desc = mk(OP_WREN,   3'd0, 5'd0, LANE_X1, 1'b0);
      C_WRDI:        d.desc = mk(OP_WRDI,   3'd0, 5'd0, LANE_X1, 1'b0);
      C_RST_EN:      d.desc = mk(OP_RST_EN, 3'd0, 5'd0, LANE_X1, 1'b0);
      C_RST:   begin d.desc = mk(OP_RST,    3'd0, 5'd0, LANE_X1, 1'b0); d.rst = 1'b1; end
      C_SE: begin
        d.desc = mk(wb ? OP_SE_4K : OP_BLK_64K, 3'd3, 5'd0, LANE_X1, 1'b0);
        d.wr   = 1'b1;
      end
      C_BE: begin
        // Winbond: 32K block erase (addressed); others: chip erase
        d.desc = mk(wb ? OP_BLK_32K : OP_CHIP_ER, wb ? 3'd3 : 3'd0, 5'd0, LANE_X1, 1'b0);
        d.wr   = 1'b1;
      end
      C_BE64K: begin d.desc = mk(OP_BLK_64K, 3'd3, 5'd0, LANE_X1, 1'b0); d.wr = 1'b1; d.ok &= wb;  end
      C_CE:    begin d.desc = mk(OP_CHIP_ER, 3'd0, 5'd0, LANE_X1, 1'b0); d.wr = 1'b1; d.ok &= wb;  end
      C_QPP:   begin d.desc = mk(OP_QPP,     3'd3, 5'd0, LANE_X4, 1'b1); d.wr = 1'b1; d.ok &= inf; end
      C_REMS:  begin d.desc = mk(OP_REMS,    3'd3, 5'd0, LANE_X1, 1'b1);              d.ok &= inf; end
      C_RDCR:  begin d.desc = mk(OP_RDCR,    3'd0, 5'd0, LANE_X1, 1'b1);              d.ok &= inf; end
      C_WRCR:  begin d.desc = mk(OP_WRCR,    3'd0, 5'd0, LANE_X1, 1'b1); d.wr = 1'b1; d.ok &= inf; end
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH-entry FIFO with show-ahead read.
//   push/din  : write when not full
//   pop/dout  : dout is the head entry; pop advances it when not empty
//   full/empty: occupancy flags
module cmd_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty.
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end

  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/command_sequencer.sv
// QSPI command sequencer: queues {cmd, flash_type} requests and expands each
// into one or two SPI opcode descriptors (optional WREN / RST_EN prefix).
//   cmd_valid_i/cmd_ready_o, cmd_i, flash_type_i : request side
//   op_valid_o/op_ready_i, opcode_o, addr_bytes_o, dummy_o, lanes_o,
//   has_data_o, last_o                          : descriptor side (registered)
//   err_o                                       : 1-cycle pulse, unsupported pair
module command_sequencer
  import qspi_cmd_pkg::*;
#(
  parameter int FT_W      = 2,
  parameter int CMD_W     = 5,
  parameter int DEPTH     = 4,
  parameter int AUTO_WREN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [FT_W-1:0]  flash_type_i,
  output logic             op_valid_o,
  input  logic             op_ready_i,
  output logic [7:0]       opcode_o,
  output logic [2:0]       addr_bytes_o,
  output logic [4:0]       dummy_o,
  output logic [1:0]       lanes_o,
  output logic             has_data_o,
  output logic             last_o,
  output logic             err_o
);
  localparam int W = CMD_W + FT_W;

  typedef enum logic [2:0] {IDLE, DECODE, PRE, MAIN, RST2} state_e;

  state_e   state;
  logic     full, empty, pop;
  logic [W-1:0] head;
  dec_t     dec;
  op_desc_t desc_q, main_q;

  cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid_i && cmd_ready_o),
    .din   ({cmd_i, flash_type_i}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready_o = !full;
  assign pop         = (state == DECODE);
  assign dec         = lookup(5'(head[FT_W +: CMD_W]), 2'(head[FT_W-1:0]));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      op_valid_o <= 1'b0;
      err_o      <= 1'b0;
      desc_q     <= '0;
      main_q     <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: if (!empty) state <= DECODE;
        DECODE: begin
          if (!dec.ok) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else if (dec.rst || (dec.wr && AUTO_WREN != 0)) begin
            desc_q     <= pfx(dec.rst ? OP_RST_EN : OP_WREN);
            main_q     <= dec.desc;
            op_valid_o <= 1'b1;
            state      <= PRE;
          end else begin
            desc_q     <= dec.desc;
            op_valid_o <= 1'b1;
            state      <= MAIN;
          end
        end
        PRE: if (op_ready_i) begin
          desc_q <= main_q;
          state  <= MAIN;
        end
        // RST2 is a reserved encoding; the reset's 0x99 already arrives
        // through MAIN from the table, so RST2 simply shares MAIN's exit.
        MAIN, RST2: if (op_ready_i) begin
          op_valid_o <= 1'b0;
          // Skip the IDLE bubble when more work is queued.
          state <= empty ? IDLE : DECODE;
        end
        default: state <= IDLE;
      endcase
    end

  assign opcode_o     = desc_q.opcode;
  assign addr_bytes_o = desc_q.addr_bytes;
  assign dummy_o      = desc_q.dummy;
  assign lanes_o      = desc_q.lanes;
  assign has_data_o   = desc_q.has_data;
  assign last_o       = desc_q.last;
endmodule

// File: tb/tb_command_sequencer.sv
// Scoreboard bench for command_sequencer: stimulus pushes hand-computed
// expected descriptors / error pulses; a negedge monitor pops and compares.
module tb_command_sequencer;
  import qspi_cmd_pkg::*;

  logic       clk = 1'b0, reset = 1'b0;
  logic       cmd_valid_i, cmd_ready_o, op_valid_o, op_ready_i;
  logic [4:0] cmd_i;
  logic [1:0] flash_type_i;
  logic [7:0] opcode_o;
  logic [2:0] addr_bytes_o;
  logic [4:0] dummy_o;
  logic [1:0] lanes_o;
  logic       has_data_o, last_o, err_o;

  always #5 clk = ~clk;

  command_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .flash_type_i(flash_type_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .opcode_o(opcode_o), .addr_bytes_o(addr_bytes_o), .dummy_o(dummy_o),
    .lanes_o(lanes_o), .has_data_o(has_data_o), .last_o(last_o), .err_o(err_o)
  );

  typedef struct {
    bit          err;
    logic [19:0] f;   // {opcode, addr_bytes, dummy, lanes, has_data, last}
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  wire [19:0] fields = {opcode_o, addr_bytes_o, dummy_o, lanes_o, has_data_o, last_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic e_op(input logic [7:0] op, input logic [2:0] ab, input logic [4:0] dm,
                      input logic [1:0] ln, input logic hd, input logic last);
    exp_t e;
    e.err = 1'b0;
    e.f   = {op, ab, dm, ln, hd, last};
    q.push_back(e);
  endtask

  task automatic e_err();
    exp_t e;
    e.err = 1'b1;
    e.f   = '0;
    q.push_back(e);
  endtask

  // Monitor
  logic        hold = 1'b0;
  logic [19:0] snap = '0;
  always @(negedge clk) begin
    if (!reset) hold = 1'b0;
    else begin
      if (hold && op_valid_o) chk("hold_stable", 32'(fields), 32'(snap));
      hold = op_valid_o && !op_ready_i;
      snap = fields;
      if (err_o) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected: got err_o=1 required no pulse");
        end else begin
          chk("err_order", 32'(q[0].err), 32'd1);
          void'(q.pop_front());
        end
      end
      if (op_valid_o && op_ready_i) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL op_unexpected: got opcode %0h required no op", opcode_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("op_not_err", 32'(e.err), 32'd0);
          chk("op_fields", 32'(fields), 32'(e.f));
        end
      end
    end
  end

  task automatic push(input logic [4:0] c, input logic [1:0] f);
    int n = 0;
    while (!cmd_ready_o && n < 200) begin @(posedge clk); #1; n++; end
    if (!cmd_ready_o) begin
      checks++; errors++;
      $display("FAIL push_timeout: got cmd_ready_o=0 required 1");
    end
    cmd_i = c; flash_type_i = f; cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_op_valid"}, 32'(op_valid_o), 32'd0);
    chk({tag, "_fields"},   32'(fields),     32'd0);
    chk({tag, "_err"},      32'(err_o),      32'd0);
    chk({tag, "_ready"},    32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    cmd_valid_i = 1'b0; cmd_i = '0; flash_type_i = '0; op_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    reset = 1'b1; op_ready_i = 1'b1;
    @(posedge clk); #1;

    // Micron READ
    e_op(8'h03, 3'd3, 5'd0, 2'd0, 1'b1, 1'b1);
    push(C_READ, FT_MICRON);
    drain();

    // Winbond SE with WREN prefix
    e_op(8'h06, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'h20, 3'd3, 5'd0, 2'd0, 1'b0, 1'b1);
    push(C_SE, FT_WINBOND);
    drain();

    // RST on Infineon and Micron
    e_op(8'h66, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'h99, 3'd0, 5'd0, 2'd0, 1'b0, 1'b1);
    e_op(8'h66, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'h99, 3'd0, 5'd0, 2'd0, 1'b0, 1'b1);
    push(C_RST, FT_INFINEON);
    push(C_RST, FT_MICRON);
    drain();

    // Micron QPP unsupported, next command proceeds
    e_err();
    e_op(8'h0B, 3'd3, 5'd8, 2'd0, 1'b1, 1'b1);
    push(C_QPP, FT_MICRON);
    push(C_FAST_READ, FT_MICRON);
    drain();

    // QUAD_IO_READ with downstream stalled 5 cycles
    op_ready_i = 1'b0;
    e_op(8'hEB, 3'd3, 5'd6, 2'd2, 1'b1, 1'b1);
    push(C_QUAD_IO_READ, FT_WINBOND);
    begin
      int n = 0;
      while (!op_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    end
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid", 32'(op_valid_o), 32'd1);
    chk("stall_opcode", 32'(opcode_o), 32'hEB);
    op_ready_i = 1'b1;
    drain();

    // Back-to-back mix
    e_op(8'hBB, 3'd3, 5'd4, 2'd1, 1'b1, 1'b1);
    e_op(8'h90, 3'd3, 5'd0, 2'd0, 1'b1, 1'b1);
    e_op(8'h06, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'hD8, 3'd3, 5'd0, 2'd0, 1'b0, 1'b1);
    e_err();
    e_op(8'h06, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'h32, 3'd3, 5'd0, 2'd2, 1'b1, 1'b1);
    e_op(8'h9F, 3'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    e_op(8'h06, 3'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    e_op(8'h01, 3'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    e_err();                                    // Micron CE unsupported
    push(C_DUAL_IO_READ, FT_WINBOND);
    push(C_REMS, FT_INFINEON);
    push(C_BE64K, FT_WINBOND);
    push(C_BE64K, FT_MICRON);
    push(C_QPP, FT_INFINEON);
    push(C_JEDEC, FT_MICRON);
    push(C_WRSR, FT_WINBOND);
    push(C_CE, FT_MICRON);
    drain();

    // Fill the queue behind a stalled prefix, then reset mid-PRE
    op_ready_i = 1'b0;
    push(C_SE, FT_WINBOND);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_valid", 32'(op_valid_o), 32'd1);
    chk("pre_opcode", 32'(opcode_o), 32'h06);
    chk("pre_last", 32'(last_o), 32'd0);
    push(C_READ, FT_MICRON);
    chk("fill1_ready", 32'(cmd_ready_o), 32'd1);
    push(C_READ, FT_MICRON);
    chk("fill2_ready", 32'(cmd_ready_o), 32'd1);
    push(C_READ, FT_MICRON);
    chk("fill3_ready", 32'(cmd_ready_o), 32'd1);
    push(C_READ, FT_MICRON);
    chk("fill4_ready", 32'(cmd_ready_o), 32'd0);
    reset = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; op_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(op_valid_o), 32'd0);

    // Recovery after reset
    e_op(8'h05, 3'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    push(C_RDSR, FT_MICRON);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end
endmodule
